// File: rtl/slice_pkg.sv
// Shared defaults and FSM state types for the ping-pong slice buffer.
package slice_pkg;

    localparam int WORD_W_DEFAULT = 30;
    localparam int DEPTH_DEFAULT  = 512;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        WAIT_LOW,
        CAPTURE
    } wr_state_t;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        STREAM
    } rd_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/slice_buffer_if.sv
// Output stream from the slice buffer to the driver controller.
interface slice_buffer_if #(
    parameter int WORD_W = slice_pkg::WORD_W_DEFAULT
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/slice_ram.sv
// Simple dual-port storage for both banks; the address MSB selects the bank.
module slice_ram #(
    parameter int WORD_W = 30,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the output data register, so it is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/slice_buffer.sv
// Captures framebuffer slices into two ping-pong banks and streams them out in capture order.
// wr: WAIT_SYNC | wait for blanking   WAIT_LOW | blanking, next low is word 0   CAPTURE | writing words
// rd: IDLE | no full bank   PREFETCH | read of word 0 issued   STREAM | presenting words
module slice_buffer
    import slice_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk_33,
    input  logic              rst,
    input  logic [WORD_W-1:0] data,
    input  logic              sync,
    slice_buffer_if.master    stream,
    output logic [7:0]        drop_count,
    output logic              sync_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    wr_state_t        wr_state;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    rd_state_t        rd_state;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_next_idx;
    logic [1:0]       bank_full;
    logic [1:0]       set_mask;
    logic [1:0]       clr_mask;

    logic             ram_we;
    logic             ram_re;
    logic [IDX_W:0]   ram_wa;
    logic [IDX_W:0]   ram_ra;
    logic [WORD_W-1:0] ram_q;

    logic             wr_commit;
    logic             rd_release;
    logic             handshake;
    logic             avail_same;
    logic             avail_other;

    always_comb begin
        ram_we    = 1'b0;
        wr_commit = 1'b0;
        ram_wa    = {wr_bank, wr_idx};
        case (wr_state)
            WAIT_LOW: ram_we = !sync && !bank_full[wr_bank];
            CAPTURE: begin
                ram_we    = !sync;
                wr_commit = !sync && (wr_idx == LAST_IDX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            wr_state   <= WAIT_SYNC;
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            drop_count <= '0;
            sync_err   <= 1'b0;
        end else begin
            case (wr_state)
                WAIT_SYNC: if (sync) wr_state <= WAIT_LOW;
                WAIT_LOW: begin
                    if (!sync) begin
                        if (bank_full[wr_bank]) begin
                            drop_count <= sat_inc8(drop_count);
                            wr_state   <= WAIT_SYNC;
                        end else begin
                            wr_idx   <= IDX_W'(1);
                            wr_state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (sync) begin
                        sync_err <= 1'b1;
                        wr_idx   <= '0;
                        wr_state <= WAIT_LOW;
                    end else begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == LAST_IDX) begin
                            wr_bank  <= ~wr_bank;
                            wr_state <= WAIT_SYNC;
                        end
                    end
                end
                default: wr_state <= WAIT_SYNC;
            endcase
        end
    end

    // A bank completing this cycle counts as available so the reader can start without a bubble.
    assign handshake   = stream.out_valid && stream.out_ready;
    assign rd_release  = (rd_state == STREAM) && handshake && (rd_idx == LAST_IDX);
    assign avail_same  = bank_full[rd_bank] || (wr_commit && (wr_bank == rd_bank));
    assign avail_other = bank_full[~rd_bank] || (wr_commit && (wr_bank != rd_bank));
    assign rd_next_idx = rd_idx + 1'b1;
    assign ram_re      = (rd_state == PREFETCH) ||
                         ((rd_state == STREAM) && handshake && (rd_idx != LAST_IDX));
    assign ram_ra      = {rd_bank, (rd_state == STREAM) ? rd_next_idx : rd_idx};

    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            rd_state         <= IDLE;
            rd_bank          <= 1'b0;
            rd_idx           <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
        end else begin
            case (rd_state)
                IDLE: if (avail_same) rd_state <= PREFETCH;
                PREFETCH: begin
                    stream.out_valid <= 1'b1;
                    stream.out_last  <= 1'b0;
                    rd_state         <= STREAM;
                end
                STREAM: begin
                    if (handshake) begin
                        if (rd_idx == LAST_IDX) begin
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                            rd_idx           <= '0;
                            rd_bank          <= ~rd_bank;
                            rd_state         <= avail_other ? PREFETCH : IDLE;
                        end else begin
                            rd_idx          <= rd_next_idx;
                            stream.out_last <= (rd_next_idx == LAST_IDX);
                        end
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end

    assign set_mask = wr_commit  ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask = rd_release ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full | set_mask) & ~clr_mask;
        end
    end

    slice_ram #(
        .WORD_W (WORD_W),
        .ADDR_W (IDX_W + 1)
    ) u_ram (
        .clk     (clk_33),
        .rst     (rst),
        .wr_en   (ram_we),
        .wr_addr (ram_wa),
        .wr_data (data),
        .rd_en   (ram_re),
        .rd_addr (ram_ra),
        .rd_data (ram_q)
    );

    assign stream.out_data = ram_q;
endmodule

// File: tb/tb_slice_buffer.sv
// Scoreboard bench for slice_buffer: random slices, random back-pressure, reference model of buffering.
module tb_slice_buffer;
    localparam int W = 30;
    localparam int D = 512;

    logic         clk_33 = 1'b0;
    logic         rst    = 1'b1;
    logic [W-1:0] data   = '0;
    logic         sync   = 1'b0;
    logic [7:0]   drop_count;
    logic         sync_err;

    slice_buffer_if #(.WORD_W(W)) stream ();

    slice_buffer #(.WORD_W(W), .DEPTH(D)) dut (
        .clk_33     (clk_33),
        .rst        (rst),
        .data       (data),
        .sync       (sync),
        .stream     (stream),
        .drop_count (drop_count),
        .sync_err   (sync_err)
    );

    always #15 clk_33 = ~clk_33;

    typedef struct {
        logic [W-1:0] d;
        bit           last;
        bit           first;
        int           commit;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] slice_words [D];
    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int committed   = 0;
    int consumed    = 0;
    int exp_drops   = 0;
    bit exp_err     = 1'b0;
    int ready_mode  = 0;
    int last_hs_cyc = -1000;
    int popped      = 0;

    always @(posedge clk_33) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic s, input logic [W-1:0] d);
        @(posedge clk_33);
        #1;
        sync = s;
        data = d;
    endtask

    // A slice is kept when fewer than two captured slices are still waiting or streaming at its first word.
    task automatic send_slice(input int blank, input int abort_at, input bit random_data);
        bit accepted = 1'b0;
        logic [W-1:0] w;
        exp_t e;
        for (int b = 0; b < blank; b++) drive(1'b1, W'($urandom));
        for (int i = 0; i < D; i++) begin
            if (i == abort_at) begin
                drive(1'b1, '0);
                if (accepted) exp_err = 1'b1;
                return;
            end
            w = random_data ? W'($urandom) : W'(i);
            drive(1'b0, w);
            if (i == 0) begin
                accepted = (committed - consumed) < 2;
                if (!accepted && exp_drops < 255) exp_drops++;
            end
            slice_words[i] = w;
            if (i == D - 1 && accepted) begin
                committed++;
                for (int j = 0; j < D; j++) begin
                    e.d      = slice_words[j];
                    e.last   = (j == D - 1);
                    e.first  = (j == 0);
                    e.commit = cyc;
                    expq.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 20000) begin
            @(negedge clk_33);
            n++;
        end
        check("drain_timeout", expq.size(), 0);
        repeat (4) @(negedge clk_33);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_drop_count"}, drop_count, exp_drops);
        check({tag, "_sync_err"}, sync_err, exp_err);
    endtask

    initial begin
        stream.out_ready = 1'b0;
        forever begin
            @(posedge clk_33);
            #1;
            case (ready_mode)
                0: stream.out_ready = 1'b1;
                1: stream.out_ready = ~stream.out_ready;
                2: stream.out_ready = 1'b0;
                3: stream.out_ready = ($urandom_range(0, 1) == 1);
                default: stream.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops one expected word each time a new word is presented, checks hold/no-bubble rules.
    initial begin
        bit           pv = 1'b0, pr = 1'b0, plast = 1'b0, cur_last = 1'b0;
        logic [W-1:0] pd = '0;
        exp_t         e;
        int           want;
        forever begin
            @(negedge clk_33);
            if (rst) begin
                pv = 1'b0; pr = 1'b0; plast = 1'b0; cur_last = 1'b0;
                continue;
            end
            if (!stream.out_valid) check("last_without_valid", stream.out_last, 0);
            if (pv && !pr) begin
                check("stall_valid", stream.out_valid, 1);
                check("stall_data", stream.out_data, pd);
            end
            if (pv && pr && !plast) check("no_bubble", stream.out_valid, 1);
            if (stream.out_valid && !(pv && !pr)) begin
                if (expq.size() == 0) begin
                    check("spurious_word", expq.size(), 1);
                end else begin
                    e = expq.pop_front();
                    popped++;
                    cur_last = e.last;
                    check("word_data", stream.out_data, e.d);
                    check("word_last", stream.out_last, e.last);
                    if (e.first) begin
                        want = ((e.commit > last_hs_cyc) ? e.commit : last_hs_cyc) + 2;
                        check("first_word_latency", cyc, want);
                    end
                end
            end
            if (stream.out_valid && stream.out_ready && cur_last) begin
                consumed++;
                last_hs_cyc = cyc;
            end
            pv    = stream.out_valid;
            pr    = stream.out_ready;
            pd    = stream.out_data;
            plast = cur_last;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int target;
        int n;
        int abort_at;
        repeat (3) @(posedge clk_33);
        #5;
        check("rst_out_valid", stream.out_valid, 0);
        check("rst_out_last", stream.out_last, 0);
        check("rst_out_data", stream.out_data, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_sync_err", sync_err, 0);
        @(negedge clk_33);
        rst = 1'b0;

        ready_mode = 0;
        send_slice(4, -1, 1'b0);
        drain();
        check_status("index_slice");

        ready_mode = 1;
        send_slice(3, -1, 1'b1);
        drain();

        ready_mode = 2;
        send_slice(4, -1, 1'b1);
        send_slice(4, -1, 1'b1);
        send_slice(4, -1, 1'b1);
        idle(10);
        check("held_ready_drop_count", drop_count, 1);
        check_status("held_ready");
        ready_mode = 0;
        drain();

        send_slice(4, 100, 1'b1);
        send_slice(2, -1, 1'b1);
        drain();
        check("abort_sync_err", sync_err, 1);
        check_status("abort");

        send_slice(1, -1, 1'b1);
        send_slice(1, -1, 1'b1);
        drain();

        for (int s = 0; s < 14; s++) begin
            ready_mode = $urandom_range(0, 4);
            abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, D - 1) : -1;
            send_slice($urandom_range(1, 6), abort_at, 1'b1);
        end
        ready_mode = 0;
        drain();
        check_status("random");

        target = popped + 301;
        send_slice(2, -1, 1'b0);
        n = 0;
        while (popped < target && n < 5000) begin
            @(negedge clk_33);
            n++;
        end
        check("mid_stream_reach", popped >= target, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", stream.out_valid, 0);
        check("async_rst_out_last", stream.out_last, 0);
        check("async_rst_out_data", stream.out_data, 0);
        check("async_rst_drop_count", drop_count, 0);
        check("async_rst_sync_err", sync_err, 0);
        expq.delete();
        committed   = 0;
        consumed    = 0;
        exp_drops   = 0;
        exp_err     = 1'b0;
        last_hs_cyc = -1000;
        repeat (2) @(posedge clk_33);
        #5;
        rst = 1'b0;
        send_slice(3, -1, 1'b0);
        drain();
        check_status("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/slice_buffer.md
SLICE_BUFFER -- requirements
Module: slice_buffer

Interface
REQ-001 SHALL have parameter WORD_W, default 30, meaning width of one pixel-column data word.
REQ-002 SHALL have parameter DEPTH, default 512, meaning words per captured slice (power of two, ≥4).
REQ-003 SHALL have port clk_33  in  1  single clock for all logic.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data  in  WORD_W  framebuffer word stream, one word per cycle.
REQ-006 SHALL have port sync  in  1  slice sync from framebuffer; high = blanking.
REQ-007 SHALL have port out_data  out  WORD_W  buffered slice word to driver controller.
REQ-008 SHALL have port out_valid  out  1  out_data valid.
REQ-009 SHALL have port out_ready  in  1  consumer accepts word when out_valid && out_ready.
REQ-010 SHALL have port out_last  out  1  high with word DEPTH-1 of a slice.
REQ-011 SHALL have port drop_count  out  8  slices dropped because both banks full; saturates at 255.
REQ-012 SHALL have port sync_err  out  1  sticky: sync reasserted during capture.

Function
REQ-013 SHALL hold two banks of DEPTH x WORD_W storage used ping-pong.
REQ-014 Write FSM SHALL have states WAIT_SYNC, WAIT_LOW, CAPTURE.
REQ-015 WAIT_SYNC -> WAIT_LOW when sync=1; WAIT_LOW -> CAPTURE on first cycle with sync=0; the data word on that cycle SHALL be word 0.
REQ-016 CAPTURE SHALL write one word per cycle at write address 0..DEPTH-1, then mark the bank full and return to WAIT_SYNC on the cycle word DEPTH-1 is written.
REQ-017 If sync=1 during CAPTURE, the partial slice SHALL be discarded (bank stays free), sync_err set, and FSM SHALL go to WAIT_LOW.
REQ-018 On entry to CAPTURE, if no bank is free, the slice SHALL be skipped (no writes), drop_count incremented by 1 (saturating), FSM returns to WAIT_SYNC.
REQ-019 Write bank selection SHALL alternate; a bank being read is never written.
REQ-020 Read FSM SHALL have states IDLE, PREFETCH, STREAM.
REQ-021 IDLE -> PREFETCH when oldest full bank exists; first word SHALL appear with out_valid=1 exactly 2 cycles after the bank-full cycle (1-cycle RAM read latency).
REQ-022 In STREAM, out_data/out_valid SHALL be held stable while out_ready=0; a new word SHALL be presented the cycle after each handshake, no bubbles while out_ready=1.
REQ-023 out_last SHALL be high iff out_valid and current word index = DEPTH-1.
REQ-024 On handshake of the last word the bank SHALL be freed that cycle; if the other bank is full, its word 0 SHALL be valid 2 cycles later, else IDLE.
REQ-025 Slices SHALL be read in capture order.
REQ-026 Simultaneous bank-full (write) and bank-free (read) in one cycle SHALL both take effect; free-count never exceeds 2 or drops below 0.
REQ-027 Address counters SHALL be log2(DEPTH) bits and wrap to 0 after DEPTH-1.

Reset
REQ-028 On rst: both FSMs to WAIT_SYNC/IDLE, both banks free, out_valid=0, out_last=0, out_data=0, drop_count=0, sync_err=0.
REQ-029 rst mid-capture or mid-stream SHALL abandon the slice; RAM contents need not be cleared.
REQ-030 sync_err SHALL clear only on rst.

Structure
REQ-031 Package slice_pkg SHALL hold WORD_W, DEPTH defaults and write/read FSM state enums.
REQ-032 Storage SHALL be one sub-module slice_ram: simple dual-port, 2*DEPTH words, registered read, bank selected by address MSB.

Verification
REQ-033 Sync high 4 cycles, then words 0..511 = index -> out stream 0..511 in order, out_last on 511, first out_valid 2 cycles after word 511 written.
REQ-034 out_ready toggling 1/0 every cycle during stream -> no word lost/duplicated, out_data stable while stalled.
REQ-035 out_ready=0 held, three complete slices captured -> first two buffered, drop_count=1; releasing ready outputs slices 1 and 2 only.
REQ-036 sync reasserted at capture word 100 -> sync_err=1, no output for that slice; next full slice streams correctly.
REQ-037 Back-to-back slices, out_ready=1 -> second slice word 0 follows first slice's last handshake by 2 cycles.
REQ-038 rst asserted mid-stream at word 300 -> out_valid=0 asynchronously, drop_count=0, next full slice streams from word 0.
